// File: rtl/cfg_seq_ctrl.sv
// Configuration sequencer for the chip-select configuration path.
// Sequence: config reset -> config clock enable -> wait for write request -> stream a frame
// of DEPTH words -> read-back window. Failed read-backs retry the frame; after MAX_RETRY
// failures the block parks in an error state until clr_err.
module cfg_seq_ctrl #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned RST_CYC   = 7,
  parameter int unsigned WAIT_CYC  = 4,
  parameter int unsigned RD_CYC    = 6,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned INST_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_en,
  input  logic              flag_cs,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] waddr,
  output logic              cs_o,
  output logic [INST_W-1:0] inst,
  output logic [2:0]        state_o,
  output logic              rst_cs,
  output logic              clk_cs_en,
  output logic [7:0]        retry_cnt,
  output logic              done,
  output logic              err
);

  // Shared cycle counter must reach the longest timed state minus one.
  localparam int unsigned CntMaxA = (RST_CYC > WAIT_CYC) ? RST_CYC : WAIT_CYC;
  localparam int unsigned CntMax  = (CntMaxA > RD_CYC) ? CntMaxA : RD_CYC;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StRst  = 3'd0,
    StClk  = 3'd1,
    StWait = 3'd2,
    StWr   = 3'd3,
    StRd   = 3'd4,
    StErr  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [7:0]        retry_q, retry_d;

  // State and datapath registers, asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRst;
      cnt_q   <= '0;
      waddr_q <= '0;
      inst_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      inst_q  <= inst_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic plus the Mealy outputs cs_o and done.
  // done is combinational: it is high during the last read-back cycle when flag_cs=1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    inst_d  = inst_q;
    retry_d = retry_q;
    cs_o    = 1'b0;
    done    = 1'b0;
    case (state_q)
      StRst: begin
        if (cnt_q == CntW'(RST_CYC - 1)) state_d = StClk;
        else                              cnt_d   = cnt_q + 1'b1;
      end
      StClk: state_d = StWait;
      StWait: begin
        // Counter saturates; a write request only counts once the minimum wait has elapsed.
        if (cnt_q == CntW'(WAIT_CYC - 1)) begin
          if (we_en) begin
            state_d = StWr;
            waddr_d = '0;
            retry_d = '0;
            // Index 0 is reserved for "no frame since reset", so the wrap skips it.
            inst_d  = (inst_q == '1) ? INST_W'(1) : inst_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWr: begin
        if (waddr_q < ADDR_W'(DEPTH)) begin
          cs_o    = 1'b1;
          waddr_d = waddr_q + 1'b1;
        end else begin
          state_d = StRd;
        end
      end
      StRd: begin
        if (cnt_q == CntW'(RD_CYC - 1)) begin
          if (flag_cs) begin
            state_d = StWait;
            done    = 1'b1;
          end else begin
            retry_d = retry_q + 1'b1;
            if (retry_d == 8'(MAX_RETRY)) begin
              state_d = StErr;
            end else begin
              state_d = StWr;
              waddr_d = '0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StErr: begin
        if (clr_err) begin
          state_d = StRst;
          retry_d = '0;
        end
      end
      default: state_d = StRst;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    state_o   = state_q;
    rst_cs    = (state_q == StRst);
    clk_cs_en = (state_q != StRst);
    err       = (state_q == StErr);
    waddr     = waddr_q;
    inst      = inst_q;
    retry_cnt = retry_q;
  end

endmodule
